fp8_dot_accumulator: RTL and testbench

- Parametrised successor to the single-lane 8-bit mini-float multiply/accumulate unit.
- Accepts LANES pairs of packed mini-float operands per beat over a valid/ready handshake and multiplies each pair exactly. Sums the lane products and accumulates them into a saturating signed integer accumulator through a 3-stage pipeline.
- An explicit clear sequence drains the pipeline, snapshots the result and flags, and restarts accumulation. The host reads the result a slice at a time.

---
 rtl/fp8_dot_accumulator.sv | 218 +++++++++++++++++++++
 tb/tb_fp8_dot_accumulator.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp8_dot_accumulator.sv
// Multi-lane mini-float dot-product unit: exact lane products are summed and folded into a
// saturating signed accumulator, with a drain/snapshot/clear sequence and sliced readout.
module fp8_dot_accumulator #(
  parameter int unsigned EW    = 4,
  parameter int unsigned MW    = 3,
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned OUT_W = 16,
  localparam int unsigned FW   = 1 + EW + MW,
  localparam int unsigned SELW = ((ACC_W / OUT_W) > 1) ? $clog2(ACC_W / OUT_W) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*FW-1:0] in_a,
  input  logic [LANES*FW-1:0] in_b,
  input  logic                acc_clear,
  output logic                result_valid,
  output logic                result_sat,
  output logic                result_nan,
  input  logic [SELW-1:0]     out_sel,
  output logic [OUT_W-1:0]    out
);

  localparam int unsigned ProdW     = 2 * MW;
  localparam int unsigned ExpW      = EW + 1;
  localparam int unsigned TermW     = 2 * MW + 2 * ((1 << EW) - 1) + 1;
  localparam int unsigned SumW      = TermW + $clog2(LANES);
  localparam int unsigned ExtW      = ((ACC_W > SumW) ? ACC_W : SumW) + 1;
  localparam int unsigned NumSlices = ACC_W / OUT_W;

  localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W - 1){1'b1}}};
  localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W - 1){1'b0}}};

  typedef enum logic [1:0] {StRun, StDrain, StClear} state_e;

  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;
  logic   result_valid_q, result_valid_d;
  logic   result_sat_q, result_sat_d;
  logic   result_nan_q, result_nan_d;
  logic [ACC_W-1:0] result_q, result_d;

  // Stage 1: per-lane mantissa product, exponent sum, sign and invalid marker.
  logic                        s1_valid_q, s1_valid_d;
  logic [LANES-1:0][ProdW-1:0] s1_prod_q, s1_prod_d;
  logic [LANES-1:0][ExpW-1:0]  s1_exp_q, s1_exp_d;
  logic [LANES-1:0]            s1_neg_q, s1_neg_d;
  logic [LANES-1:0]            s1_inv_q, s1_inv_d;

  // Stage 2: exact signed sum of all lane terms.
  logic                   s2_valid_q, s2_valid_d;
  logic signed [SumW-1:0] s2_sum_q, s2_sum_d;
  logic                   s2_nan_q, s2_nan_d;

  // Stage 3: accumulator and sticky flags.
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sat_q, sat_d;
  logic                    nan_q, nan_d;

  logic [FW-1:0]           op_a, op_b;
  logic [TermW-1:0]        lane_mag;
  logic signed [TermW-1:0] lane_term;
  logic signed [ExtW-1:0]  acc_ext;
  logic [ExtW-ACC_W:0]     acc_hi;

  always_comb begin
    s1_valid_d = in_valid && in_ready_q;
    s1_prod_d  = s1_prod_q;
    s1_exp_d   = s1_exp_q;
    s1_neg_d   = s1_neg_q;
    s1_inv_d   = s1_inv_q;
    op_a       = '0;
    op_b       = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      op_a = in_a[i*FW +: FW];
      op_b = in_b[i*FW +: FW];
      if (s1_valid_d) begin
        s1_prod_d[i] = ProdW'(op_a[MW-1:0]) * ProdW'(op_b[MW-1:0]);
        s1_exp_d[i]  = ExpW'(op_a[MW +: EW]) + ExpW'(op_b[MW +: EW]);
        s1_neg_d[i]  = op_a[FW-1] ^ op_b[FW-1];
        s1_inv_d[i]  = (op_a == '1) || (op_b == '1);
      end
    end
  end

  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_nan_d   = s2_nan_q;
    lane_mag   = '0;
    lane_term  = '0;
    if (s1_valid_q) begin
      s2_sum_d = '0;
      s2_nan_d = 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
        lane_mag = TermW'(s1_prod_q[i]) << s1_exp_q[i];
        if (s1_inv_q[i]) begin
          lane_mag = '0;
        end
        // Negating a zero magnitude yields zero, so no negative zero can appear.
        lane_term = s1_neg_q[i] ? -$signed(lane_mag) : $signed(lane_mag);
        s2_sum_d  = s2_sum_d + SumW'(lane_term);
        s2_nan_d  = s2_nan_d | s1_inv_q[i];
      end
    end
  end

  always_comb begin
    acc_d   = acc_q;
    sat_d   = sat_q;
    nan_d   = nan_q;
    acc_ext = ExtW'(acc_q) + ExtW'(s2_sum_q);
    // The sum fits ACC_W exactly when all bits from the ACC_W sign bit up agree.
    acc_hi  = acc_ext[ExtW-1:ACC_W-1];
    if (s2_valid_q) begin
      if (s2_nan_q) begin
        nan_d = 1'b1;
      end
      if ((acc_hi != '0) && (acc_hi != '1)) begin
        sat_d = 1'b1;
        acc_d = acc_ext[ExtW-1] ? AccMin : AccMax;
      end else begin
        acc_d = acc_ext[ACC_W-1:0];
      end
    end
    if (state_q == StClear) begin
      acc_d = '0;
      sat_d = 1'b0;
      nan_d = 1'b0;
    end
  end

  always_comb begin
    state_d        = state_q;
    result_d       = result_q;
    result_sat_d   = result_sat_q;
    result_nan_d   = result_nan_q;
    result_valid_d = 1'b0;
    unique case (state_q)
      StRun: begin
        if (acc_clear) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!s1_valid_q && !s2_valid_q) begin
          state_d = StClear;
        end
      end
      StClear: begin
        state_d        = StRun;
        result_d       = acc_q;
        result_sat_d   = sat_q;
        result_nan_d   = nan_q;
        result_valid_d = 1'b1;
      end
      default: state_d = StRun;
    endcase
    in_ready_d = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StRun;
      in_ready_q     <= 1'b1;
      result_valid_q <= 1'b0;
      result_sat_q   <= 1'b0;
      result_nan_q   <= 1'b0;
      result_q       <= '0;
      s1_valid_q     <= 1'b0;
      s1_prod_q      <= '0;
      s1_exp_q       <= '0;
      s1_neg_q       <= '0;
      s1_inv_q       <= '0;
      s2_valid_q     <= 1'b0;
      s2_sum_q       <= '0;
      s2_nan_q       <= 1'b0;
      acc_q          <= '0;
      sat_q          <= 1'b0;
      nan_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      result_valid_q <= result_valid_d;
      result_sat_q   <= result_sat_d;
      result_nan_q   <= result_nan_d;
      result_q       <= result_d;
      s1_valid_q     <= s1_valid_d;
      s1_prod_q      <= s1_prod_d;
      s1_exp_q       <= s1_exp_d;
      s1_neg_q       <= s1_neg_d;
      s1_inv_q       <= s1_inv_d;
      s2_valid_q     <= s2_valid_d;
      s2_sum_q       <= s2_sum_d;
      s2_nan_q       <= s2_nan_d;
      acc_q          <= acc_d;
      sat_q          <= sat_d;
      nan_q          <= nan_d;
    end
  end

  always_comb begin
    out = '0;
    for (int i = 0; i < int'(NumSlices); i++) begin
      if (int'(out_sel) == i) begin
        out = result_q[i*OUT_W +: OUT_W];
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign result_valid = result_valid_q;
  assign result_sat   = result_sat_q;
  assign result_nan   = result_nan_q;

endmodule

// File: tb/tb_fp8_dot_accumulator.sv
// Bench for fp8_dot_accumulator: directed scenarios plus random beats, all checked against a
// cycle-level behavioural model of the accumulation, handshake and result timing.
module tb_fp8_dot_accumulator;

  localparam longint MaxAcc = 64'sd2147483647;
  localparam longint MinAcc = -64'sd2147483648;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        acc_clear;
  logic        result_valid;
  logic        result_sat;
  logic        result_nan;
  logic [0:0]  out_sel;
  logic [15:0] out;

  fp8_dot_accumulator dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .acc_clear   (acc_clear),
    .result_valid(result_valid),
    .result_sat  (result_sat),
    .result_nan  (result_nan),
    .out_sel     (out_sel),
    .out         (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  int     cyc = 0;
  int     last_beat = -100;
  int     rv_edge = 0;
  bit     m_ready = 1'b1;
  bit     pending = 1'b0;
  bit     exp_rv = 1'b0;
  bit     chk_en = 1'b0;
  longint m_acc = 0;
  bit     m_sat = 1'b0;
  bit     m_nan = 1'b0;
  longint snap = 0;
  bit     snap_sat = 1'b0;
  bit     snap_nan = 1'b0;
  logic [31:0] vis_result = '0;
  logic        vis_sat = 1'b0;
  logic        vis_nan = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Value of one operand pair as a plain signed integer: (-1)^s * mA*mB * 2^(eA+eB).
  function automatic longint pair_val(input logic [7:0] a, input logic [7:0] b);
    longint mag;
    if (a == 8'hFF || b == 8'hFF) return 0;
    mag = (longint'(a[2:0]) * longint'(b[2:0])) << (int'(a[6:3]) + int'(b[6:3]));
    return (a[7] ^ b[7]) ? -mag : mag;
  endfunction

  function automatic longint beat_sum(input logic [31:0] a, input logic [31:0] b);
    longint s = 0;
    for (int i = 0; i < 4; i++) s += pair_val(a[i*8 +: 8], b[i*8 +: 8]);
    return s;
  endfunction

  function automatic bit has_inv(input logic [31:0] a, input logic [31:0] b);
    bit r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (a[i*8 +: 8] == 8'hFF || b[i*8 +: 8] == 8'hFF) r = 1'b1;
    end
    return r;
  endfunction

  // Advance one clock edge and update the model with what the DUT sees at that edge.
  task automatic step();
    longint s;
    @(posedge clk);
    cyc++;
    exp_rv = 1'b0;
    if (reset) begin
      m_acc = 0; m_sat = 1'b0; m_nan = 1'b0; m_ready = 1'b1; pending = 1'b0;
      last_beat = -100; vis_result = '0; vis_sat = 1'b0; vis_nan = 1'b0;
    end else begin
      if (in_valid && m_ready) begin
        s = m_acc + beat_sum(in_a, in_b);
        if (s > MaxAcc) begin
          s = MaxAcc; m_sat = 1'b1;
        end else if (s < MinAcc) begin
          s = MinAcc; m_sat = 1'b1;
        end
        m_acc = s;
        if (has_inv(in_a, in_b)) m_nan = 1'b1;
        last_beat = cyc;
      end
      if (acc_clear && m_ready) begin
        snap = m_acc; snap_sat = m_sat; snap_nan = m_nan;
        m_acc = 0; m_sat = 1'b0; m_nan = 1'b0; m_ready = 1'b0; pending = 1'b1;
        // Last beat lands in the accumulator two edges after acceptance, then drain+clear.
        rv_edge = ((cyc > last_beat + 2) ? cyc : last_beat + 2) + 2;
      end else if (pending && cyc == rv_edge) begin
        pending = 1'b0; m_ready = 1'b1; exp_rv = 1'b1;
        vis_result = 32'(snap); vis_sat = snap_sat; vis_nan = snap_nan;
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic clr);
    in_valid = v; in_a = a; in_b = b; acc_clear = clr;
    step();
    in_valid = 1'b0; acc_clear = 1'b0;
  endtask

  task automatic wait_result(input string name);
    for (int i = 0; i < 20 && !exp_rv; i++) step();
    chk({name, "_rv_seen"}, 64'(exp_rv), 64'd1);
  endtask

  // Hand-computed expectation, checked against both the model and the DUT readout.
  task automatic lit(input string name, input logic [31:0] e, input logic es, input logic en);
    chk({name, "_model"}, 64'(vis_result), 64'(e));
    out_sel = 1'b0; #1;
    chk({name, "_lo"}, 64'(out), 64'(e[15:0]));
    out_sel = 1'b1; #1;
    chk({name, "_hi"}, 64'(out), 64'(e[31:16]));
    chk({name, "_sat"}, 64'(result_sat), 64'(es));
    chk({name, "_nan"}, 64'(result_nan), 64'(en));
  endtask

  function automatic logic [7:0] rnd_op();
    logic [7:0] v;
    int r;
    r = $urandom_range(0, 31);
    v = 8'($urandom);
    if (r == 0) v = 8'hFF;
    else if (r < 26) v[6:3] = 4'($urandom_range(0, 6));
    return v;
  endfunction

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("in_ready", 64'(in_ready), 64'(m_ready));
        chk("result_valid", 64'(result_valid), 64'(exp_rv));
        chk("result_sat", 64'(result_sat), 64'(vis_sat));
        chk("result_nan", 64'(result_nan), 64'(vis_nan));
        chk("out", 64'(out), 64'((out_sel == 1'b1) ? vis_result[31:16] : vis_result[15:0]));
      end
    end
  end

  initial begin
    int n;
    int low;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; acc_clear = 1'b0; out_sel = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    lit("reset", 32'h0, 1'b0, 1'b0);

    // Basic: 6 * 12 = 72, clear on a separate cycle.
    drive(1'b1, 32'h0000_000B, 32'h0000_0013, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    wait_result("basic");
    lit("basic", 32'h0000_0048, 1'b0, 1'b0);

    // Sign: -72 plus a 0*0 lane, clear presented with the beat.
    drive(1'b1, 32'h0000_088B, 32'h0000_0813, 1'b1);
    wait_result("sign");
    lit("sign", 32'hFFFF_FFB8, 1'b0, 1'b0);

    // Saturation then a clean accumulation.
    drive(1'b1, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 1'b0);
    drive(1'b1, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    wait_result("sat");
    lit("sat", 32'h7FFF_FFFF, 1'b1, 1'b0);
    drive(1'b1, 32'h0000_000B, 32'h0000_0013, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    wait_result("after_sat");
    lit("after_sat", 32'h0000_0048, 1'b0, 1'b0);

    // Invalid operand in lane 1.
    drive(1'b1, 32'h0000_FF0B, 32'h0000_1313, 1'b1);
    wait_result("nan");
    lit("nan", 32'h0000_0048, 1'b0, 1'b1);

    // Back-to-back stream with clear on the 10th accepted beat.
    in_valid = 1'b1; in_a = 32'h0000_000B; in_b = 32'h0000_0013; n = 0;
    for (int i = 0; i < 40 && n < 10; i++) begin
      acc_clear = (n == 9);
      if (m_ready) n++;
      step();
    end
    acc_clear = 1'b0;
    low = 0;
    for (int i = 0; i < 20 && !exp_rv; i++) begin
      step();
      if (!in_ready) low++;
    end
    chk("b2b_rv_seen", 64'(exp_rv), 64'd1);
    chk("b2b_ready_low", 64'(low >= 2), 64'd1);
    lit("b2b", 32'd720, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    wait_result("b2b_held");
    lit("b2b_held", 32'd72, 1'b0, 1'b0);

    // Reset in the middle of a stream.
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h0000_000B, 32'h0000_0013, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step();
    lit("mid_reset", 32'h0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    wait_result("empty_clear");
    lit("empty_clear", 32'h0, 1'b0, 1'b0);

    // Random beats, clears (some dropped while busy) and readout selects.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = {rnd_op(), rnd_op(), rnd_op(), rnd_op()};
      in_b      = {rnd_op(), rnd_op(), rnd_op(), rnd_op()};
      acc_clear = ($urandom_range(0, 19) == 0);
      out_sel   = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0; acc_clear = 1'b0;
    for (int i = 0; i < 8; i++) step();
    drive(1'b0, '0, '0, 1'b1);
    wait_result("rand_final");
    step();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
